// File: rtl/sol32_exec_unit.sv
// sol32 execute stage: two-operand ALU, one-operand ALU, flags register and condition comparator.
// Latency: ALU results, ALU flags and CondTrue are combinational; FlagsReg updates one Clock edge after FlagEnable.
// Backpressure: none; the unit accepts new operands every cycle.
// Build option: define SOL32_ALU2_MUL_EN to give alu2 Op B a 32x32 low-half multiplier (otherwise Op B returns 0).
module sol32_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] Source1,
   input  logic [WIDTH-1:0] Source2,
   input  logic             FlagEnable,
   input  logic             FlagSel,
   input  logic [WIDTH-1:0] CompSource1,
   input  logic [WIDTH-1:0] CompSource2,
   input  logic [3:0]       Cond,
   output logic [WIDTH-1:0] Result2,
   output logic [WIDTH-1:0] Result1,
   output logic [3:0]       Flags2,
   output logic [3:0]       Flags1,
   output logic [3:0]       FlagsReg,
   output logic             CondTrue
);

   // Only a 32-bit datapath is supported; bit positions below assume it.
   logic [32:0] add_sum;
   logic [32:0] sub_diff;
   logic        add_v;
   logic        sub_v;
   logic [4:0]  shamt;
   logic        slt_s;
   logic        slt_u;
   logic [31:0] alu2_res;
   logic        alu2_c;
   logic        alu2_v;

   logic [32:0] inc_sum;
   logic [32:0] dec_sum;
   logic [32:0] neg_sum;
   logic [5:0]  clz_cnt;
   logic [5:0]  ctz_cnt;
   logic [5:0]  pop_cnt;
   logic [31:0] bit_rev;
   logic [31:0] alu1_res;
   logic        alu1_c;
   logic        alu1_v;

   logic [3:0]  flags_d;
   logic [3:0]  flags_q;

   logic        cmp_eq;
   logic        cmp_lt;
   logic        cmp_ltu;
   logic        cond_true;

`ifdef SOL32_ALU2_MUL_EN
   logic [31:0] mul_lo;
   assign mul_lo = Source1 * Source2;
`endif

   // Two-operand ALU: subtraction is A + ~B + 1 so bit 32 is the no-borrow carry.
   always_comb begin
      add_sum  = {1'b0, Source1} + {1'b0, Source2};
      sub_diff = {1'b0, Source1} + {1'b0, ~Source2} + 33'd1;
      add_v    = (Source1[31] == Source2[31]) && (add_sum[31] != Source1[31]);
      sub_v    = (Source1[31] != Source2[31]) && (sub_diff[31] != Source1[31]);
      shamt    = Source2[4:0];
      slt_s    = $signed(Source1) < $signed(Source2);
      slt_u    = Source1 < Source2;
      alu2_res = '0;
      alu2_c   = 1'b0;
      alu2_v   = 1'b0;
      case (Op)
         4'h0: begin
            alu2_res = add_sum[31:0];
            alu2_c   = add_sum[32];
            alu2_v   = add_v;
         end
         4'h1: begin
            alu2_res = sub_diff[31:0];
            alu2_c   = sub_diff[32];
            alu2_v   = sub_v;
         end
         4'h2: alu2_res = Source1 & Source2;
         4'h3: alu2_res = Source1 | Source2;
         4'h4: alu2_res = Source1 ^ Source2;
         4'h5: alu2_res = Source1 << shamt;
         4'h6: alu2_res = Source1 >> shamt;
         4'h7: alu2_res = $unsigned($signed(Source1) >>> shamt);
         4'h8: alu2_res = {31'd0, slt_s};
         4'h9: alu2_res = {31'd0, slt_u};
         4'hA: alu2_res = Source1 & ~Source2;
`ifdef SOL32_ALU2_MUL_EN
         4'hB: alu2_res = mul_lo;
`else
         4'hB: alu2_res = '0;
`endif
         4'hC: alu2_res = slt_s ? Source1 : Source2;
         4'hD: alu2_res = slt_s ? Source2 : Source1;
         4'hE: alu2_res = Source2;
         default: alu2_res = Source1;
      endcase
   end

   assign Result2 = alu2_res;
   assign Flags2  = {alu2_res[31], (alu2_res == 32'd0), alu2_c, alu2_v};

   // Bit-scan helpers for CLZ, CTZ, POPCNT and bit-reverse; zero input scans to 32.
   always_comb begin
      clz_cnt = 6'd32;
      ctz_cnt = 6'd32;
      pop_cnt = 6'd0;
      bit_rev = '0;
      for (int i = 0; i < 32; i++) begin
         if (Source1[i]) clz_cnt = 6'(31 - i);
         pop_cnt    = pop_cnt + {5'd0, Source1[i]};
         bit_rev[i] = Source1[31 - i];
      end
      for (int j = 31; j >= 0; j--) begin
         if (Source1[j]) ctz_cnt = 6'(j);
      end
   end

   // One-operand ALU: NEG/INC/DEC reuse the add carry conventions (C = carry / no-borrow).
   always_comb begin
      neg_sum  = {1'b0, ~Source1} + 33'd1;
      inc_sum  = {1'b0, Source1} + 33'd1;
      dec_sum  = {1'b0, Source1} + 33'h0FFFFFFFF;
      alu1_res = '0;
      alu1_c   = 1'b0;
      alu1_v   = 1'b0;
      case (Op)
         4'h0: alu1_res = ~Source1;
         4'h1: begin
            alu1_res = neg_sum[31:0];
            alu1_c   = neg_sum[32];
            alu1_v   = Source1[31] & neg_sum[31];
         end
         4'h2: begin
            alu1_res = inc_sum[31:0];
            alu1_c   = inc_sum[32];
            alu1_v   = ~Source1[31] & inc_sum[31];
         end
         4'h3: begin
            alu1_res = dec_sum[31:0];
            alu1_c   = dec_sum[32];
            alu1_v   = Source1[31] & ~dec_sum[31];
         end
         4'h4: alu1_res = {26'd0, clz_cnt};
         4'h5: alu1_res = {26'd0, ctz_cnt};
         4'h6: alu1_res = {26'd0, pop_cnt};
         4'h7: alu1_res = {Source1[7:0], Source1[15:8], Source1[23:16], Source1[31:24]};
         4'h8: alu1_res = {{24{Source1[7]}}, Source1[7:0]};
         4'h9: alu1_res = {{16{Source1[15]}}, Source1[15:0]};
         4'hA: alu1_res = {24'd0, Source1[7:0]};
         4'hB: alu1_res = {16'd0, Source1[15:0]};
         4'hC: alu1_res = bit_rev;
         default: alu1_res = Source1;
      endcase
   end

   assign Result1 = alu1_res;
   assign Flags1  = {alu1_res[31], (alu1_res == 32'd0), alu1_c, alu1_v};

   // Next flags value: load the selected ALU's flags when enabled, otherwise hold.
   always_comb begin
      flags_d = flags_q;
      if (FlagEnable) flags_d = FlagSel ? Flags2 : Flags1;
   end

   // Flags register; reset clears only this state, the datapath stays combinational.
   always_ff @(posedge Clock) begin
      if (!Reset) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end

   assign FlagsReg = flags_q;

   // Condition comparator: codes 0-5 compare operands, 8-F test the registered flags.
   always_comb begin
      cmp_eq    = CompSource1 == CompSource2;
      cmp_lt    = $signed(CompSource1) < $signed(CompSource2);
      cmp_ltu   = CompSource1 < CompSource2;
      cond_true = 1'b0;
      case (Cond)
         4'h0: cond_true = cmp_eq;
         4'h1: cond_true = ~cmp_eq;
         4'h2: cond_true = cmp_lt;
         4'h3: cond_true = ~cmp_lt;
         4'h4: cond_true = cmp_ltu;
         4'h5: cond_true = ~cmp_ltu;
         4'h6: cond_true = 1'b1;
         4'h7: cond_true = 1'b0;
         4'h8: cond_true = flags_q[2];
         4'h9: cond_true = ~flags_q[2];
         4'hA: cond_true = flags_q[3];
         4'hB: cond_true = ~flags_q[3];
         4'hC: cond_true = flags_q[1];
         4'hD: cond_true = ~flags_q[1];
         4'hE: cond_true = flags_q[0];
         default: cond_true = ~flags_q[0];
      endcase
   end

   assign CondTrue = cond_true;

endmodule

// File: tb/tb_sol32_exec_unit.sv
// Self-checking bench for sol32_exec_unit: directed vector table, flag-register sequences, randomized model check.
// Latency: combinational outputs sampled 1ns after input change; FlagsReg sampled 1ns after the clock edge.
// Backpressure: not applicable.
module tb_sol32_exec_unit;

   logic        Clock;
   logic        Reset;
   logic [3:0]  Op;
   logic [31:0] Source1;
   logic [31:0] Source2;
   logic        FlagEnable;
   logic        FlagSel;
   logic [31:0] CompSource1;
   logic [31:0] CompSource2;
   logic [3:0]  Cond;
   logic [31:0] Result2;
   logic [31:0] Result1;
   logic [3:0]  Flags2;
   logic [3:0]  Flags1;
   logic [3:0]  FlagsReg;
   logic        CondTrue;

   int checks = 0;
   int errors = 0;

   sol32_exec_unit #(.WIDTH(32)) dut (
      .Clock(Clock), .Reset(Reset), .Op(Op), .Source1(Source1), .Source2(Source2),
      .FlagEnable(FlagEnable), .FlagSel(FlagSel), .CompSource1(CompSource1),
      .CompSource2(CompSource2), .Cond(Cond), .Result2(Result2), .Result1(Result1),
      .Flags2(Flags2), .Flags1(Flags1), .FlagsReg(FlagsReg), .CondTrue(CondTrue)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [1:0]  unit;    // 0 = alu2, 1 = alu1, 2 = comparator
      logic [3:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic [3:0]  exp_f;
   } vec_t;

   vec_t vecs[$];

   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [1:0] u, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input logic [3:0] f);
      vec_t v;
      v.unit = u; v.code = c; v.a = a; v.b = b; v.exp = e; v.exp_f = f;
      vecs.push_back(v);
   endtask

   function automatic logic in_range(input longint x);
      return (x <= MAXS) && (x >= MINS);
   endfunction

   // Reference alu2: returns {flags, result}, computed with wide arithmetic.
   function automatic logic [35:0] m_alu2(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint sa = $signed(a);
      longint sb = $signed(b);
      longint unsigned prod;
      int s = int'(b % 32);
      logic [31:0] r = '0;
      logic c = 1'b0;
      logic v = 1'b0;
      case (op)
         4'h0: begin r = 32'(ua + ub); c = (ua + ub) > 64'hFFFFFFFF; v = !in_range(sa + sb); end
         4'h1: begin r = 32'(ua - ub); c = (a >= b); v = !in_range(sa - sb); end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = a << s;
         4'h6: r = a >> s;
         4'h7: begin
            r = a >> s;
            if (a[31]) r = r | ~(32'hFFFFFFFF >> s);
         end
         4'h8: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h9: r = (ua < ub) ? 32'd1 : 32'd0;
         4'hA: r = a & ~b;
         4'hB: begin
            prod = ua * ub;
`ifdef SOL32_ALU2_MUL_EN
            r = 32'(prod);
`else
            r = 32'(prod & 64'd0);
`endif
         end
         4'hC: r = (sa <= sb) ? a : b;
         4'hD: r = (sa >= sb) ? a : b;
         4'hE: r = b;
         default: r = a;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   // Reference alu1: returns {flags, result}.
   function automatic logic [35:0] m_alu1(input logic [3:0] op, input logic [31:0] a);
      longint unsigned ua = 64'(a);
      longint sa = $signed(a);
      longint t;
      int n = 0;
      logic [31:0] r = '0;
      logic c = 1'b0;
      logic v = 1'b0;
      case (op)
         4'h0: r = ~a;
         4'h1: begin r = 32'(64'd0 - ua); c = (a == 32'd0); v = !in_range(-sa); end
         4'h2: begin r = 32'(ua + 1); c = (ua + 1) > 64'hFFFFFFFF; v = !in_range(sa + 1); end
         4'h3: begin r = 32'(ua - 1); c = (a >= 32'd1); v = !in_range(sa - 1); end
         4'h4: begin while (n < 32 && a[31 - n] == 1'b0) n++; r = 32'(n); end
         4'h5: begin while (n < 32 && a[n] == 1'b0) n++; r = 32'(n); end
         4'h6: r = 32'($countones(a));
         4'h7: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
         4'h8: begin t = longint'(a % 256); if (t >= 128) t = t - 256; r = 32'(t); end
         4'h9: begin t = longint'(a % 65536); if (t >= 32768) t = t - 65536; r = 32'(t); end
         4'hA: r = a % 256;
         4'hB: r = a % 65536;
         4'hC: for (int i = 0; i < 32; i++) r[31 - i] = a[i];
         default: r = a;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   // Reference comparator; fl is the registered {N,Z,C,V}.
   function automatic logic m_cond(input logic [3:0] cd, input logic [31:0] x, input logic [31:0] y,
                                   input logic [3:0] fl);
      longint sx = $signed(x);
      longint sy = $signed(y);
      case (cd)
         4'h0: return x == y;
         4'h1: return x != y;
         4'h2: return sx < sy;
         4'h3: return sx >= sy;
         4'h4: return x < y;
         4'h5: return x >= y;
         4'h6: return 1'b1;
         4'h7: return 1'b0;
         4'h8: return fl[2] == 1'b1;
         4'h9: return fl[2] == 1'b0;
         4'hA: return fl[3] == 1'b1;
         4'hB: return fl[3] == 1'b0;
         4'hC: return fl[1] == 1'b1;
         4'hD: return fl[1] == 1'b0;
         4'hE: return fl[0] == 1'b1;
         default: return fl[0] == 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h00000000;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         4: return 32'h00000001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [35:0] m2;
      logic [35:0] m1;
      logic [3:0]  mflags;
      logic [31:0] mul_exp;
      logic [3:0]  mul_f;

      // Reset with FlagEnable asserted and nonzero ALU flags: reset must win.
      Reset = 1'b0; FlagEnable = 1'b1; FlagSel = 1'b1;
      Op = 4'h0; Source1 = 32'hFFFFFFFF; Source2 = 32'h1;
      CompSource1 = '0; CompSource2 = '0; Cond = 4'h8;
      @(posedge Clock); #1;
      check("reset_flagsreg", {28'd0, FlagsReg}, 32'h0);
      check("reset_cond_z", {31'd0, CondTrue}, 32'h0);
      check("reset_comb_result2", Result2, 32'h0);
      check("reset_comb_flags2", {28'd0, Flags2}, 32'h6);
      Reset = 1'b1; FlagEnable = 1'b0;

      // Directed table: {unit, code, a, b, expected value, expected flags}.
      add_vec(0, 4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
      add_vec(0, 4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
      add_vec(0, 4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011);
      add_vec(0, 4'h1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b1000);
      add_vec(0, 4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110);
      add_vec(0, 4'h7, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000);
      add_vec(0, 4'h5, 32'h12345678, 32'h00000020, 32'h12345678, 4'b0000);
      add_vec(0, 4'h6, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000);
      add_vec(0, 4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000);
      add_vec(0, 4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100);
      add_vec(0, 4'hA, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 4'b0000);
      add_vec(0, 4'hC, 32'h80000000, 32'h00000007, 32'h80000000, 4'b1000);
      add_vec(0, 4'hD, 32'h80000000, 32'h00000007, 32'h00000007, 4'b0000);
      add_vec(0, 4'hE, 32'h00000001, 32'hFFFF0000, 32'hFFFF0000, 4'b1000);
      add_vec(0, 4'hF, 32'h00000000, 32'h12345678, 32'h00000000, 4'b0100);
      add_vec(1, 4'h4, 32'h00010000, 32'h0, 32'd15, 4'b0000);
      add_vec(1, 4'h4, 32'h00000000, 32'h0, 32'd32, 4'b0000);
      add_vec(1, 4'h5, 32'h00000000, 32'h0, 32'd32, 4'b0000);
      add_vec(1, 4'h5, 32'h80000000, 32'h0, 32'd31, 4'b0000);
      add_vec(1, 4'h6, 32'h0000F0F0, 32'h0, 32'd8, 4'b0000);
      add_vec(1, 4'h8, 32'h00000080, 32'h0, 32'hFFFFFF80, 4'b1000);
      add_vec(1, 4'h1, 32'h00000000, 32'h0, 32'h00000000, 4'b0110);
      add_vec(1, 4'h1, 32'h80000000, 32'h0, 32'h80000000, 4'b1001);
      add_vec(1, 4'h2, 32'hFFFFFFFF, 32'h0, 32'h00000000, 4'b0110);
      add_vec(1, 4'h2, 32'h7FFFFFFF, 32'h0, 32'h80000000, 4'b1001);
      add_vec(1, 4'h3, 32'h00000000, 32'h0, 32'hFFFFFFFF, 4'b1000);
      add_vec(1, 4'h3, 32'h80000000, 32'h0, 32'h7FFFFFFF, 4'b0011);
      add_vec(1, 4'h7, 32'h11223344, 32'h0, 32'h44332211, 4'b0000);
      add_vec(1, 4'hC, 32'h00000001, 32'h0, 32'h80000000, 4'b1000);
      add_vec(1, 4'h9, 32'h00008000, 32'h0, 32'hFFFF8000, 4'b1000);
      add_vec(1, 4'hA, 32'hFFFFFF80, 32'h0, 32'h00000080, 4'b0000);
      add_vec(1, 4'hB, 32'hFFFF8001, 32'h0, 32'h00008001, 4'b0000);
      add_vec(1, 4'h0, 32'h00000000, 32'h0, 32'hFFFFFFFF, 4'b1000);
      add_vec(1, 4'hD, 32'h00000005, 32'h0, 32'h00000005, 4'b0000);
      add_vec(2, 4'h2, 32'hFFFFFFFF, 32'h00000001, 32'd1, 4'b0000);
      add_vec(2, 4'h4, 32'hFFFFFFFF, 32'h00000001, 32'd0, 4'b0000);
      add_vec(2, 4'h1, 32'hFFFFFFFF, 32'h00000001, 32'd1, 4'b0000);
      add_vec(2, 4'h7, 32'hFFFFFFFF, 32'h00000001, 32'd0, 4'b0000);
      add_vec(2, 4'h6, 32'hFFFFFFFF, 32'h00000001, 32'd1, 4'b0000);
      add_vec(2, 4'h0, 32'h00000005, 32'h00000005, 32'd1, 4'b0000);
      add_vec(2, 4'h3, 32'h00000001, 32'hFFFFFFFF, 32'd1, 4'b0000);
      add_vec(2, 4'h5, 32'h00000001, 32'hFFFFFFFF, 32'd0, 4'b0000);

      foreach (vecs[k]) begin
         @(negedge Clock);
         if (vecs[k].unit == 2'd2) begin
            Cond = vecs[k].code; CompSource1 = vecs[k].a; CompSource2 = vecs[k].b;
            #1;
            check($sformatf("vec%0d_cond", k), {31'd0, CondTrue}, vecs[k].exp);
         end else begin
            Op = vecs[k].code; Source1 = vecs[k].a; Source2 = vecs[k].b;
            #1;
            if (vecs[k].unit == 2'd0) begin
               check($sformatf("vec%0d_result2", k), Result2, vecs[k].exp);
               check($sformatf("vec%0d_flags2", k), {28'd0, Flags2}, {28'd0, vecs[k].exp_f});
            end else begin
               check($sformatf("vec%0d_result1", k), Result1, vecs[k].exp);
               check($sformatf("vec%0d_flags1", k), {28'd0, Flags1}, {28'd0, vecs[k].exp_f});
            end
         end
      end

      // Latch alu2 ADD flags, then test flag-based conditions against the registered value.
      @(negedge Clock);
      Op = 4'h0; Source1 = 32'hFFFFFFFF; Source2 = 32'h1; FlagSel = 1'b1; FlagEnable = 1'b1;
      @(posedge Clock); #1;
      FlagEnable = 1'b0;
      check("seq_latch_add_flags", {28'd0, FlagsReg}, 32'h6);
      Cond = 4'hC; #1; check("seq_cond_c_set", {31'd0, CondTrue}, 32'd1);
      Cond = 4'h8; #1; check("seq_cond_z_set", {31'd0, CondTrue}, 32'd1);
      Cond = 4'hA; #1; check("seq_cond_n_set", {31'd0, CondTrue}, 32'd0);
      Cond = 4'hF; #1; check("seq_cond_v_clear", {31'd0, CondTrue}, 32'd1);

      // ALU flags change with FlagEnable low: register must hold.
      @(negedge Clock);
      Op = 4'h1; Source1 = 32'h80000000; Source2 = 32'h1;
      #1; check("seq_hold_flags2_changed", {28'd0, Flags2}, 32'h3);
      @(posedge Clock); #1;
      check("seq_hold_flagsreg", {28'd0, FlagsReg}, 32'h6);
      Cond = 4'hE; #1; check("seq_hold_cond_v", {31'd0, CondTrue}, 32'd0);

      // Latch alu1 NEG flags via FlagSel=0.
      @(negedge Clock);
      Op = 4'h1; Source1 = 32'h80000000; FlagSel = 1'b0; FlagEnable = 1'b1;
      @(posedge Clock); #1;
      FlagEnable = 1'b0;
      check("seq_latch_neg_flags", {28'd0, FlagsReg}, 32'h9);
      Cond = 4'hE; #1; check("seq_cond_v_set", {31'd0, CondTrue}, 32'd1);
      Cond = 4'h9; #1; check("seq_cond_z_clear", {31'd0, CondTrue}, 32'd1);
      Cond = 4'hD; #1; check("seq_cond_c_clear", {31'd0, CondTrue}, 32'd1);
      Cond = 4'hB; #1; check("seq_cond_n_clear", {31'd0, CondTrue}, 32'd0);

      // Op B multiply / stub.
`ifdef SOL32_ALU2_MUL_EN
      mul_exp = 32'd15; mul_f = 4'b0000;
`else
      mul_exp = 32'd0;  mul_f = 4'b0100;
`endif
      @(negedge Clock);
      Op = 4'hB; Source1 = 32'd3; Source2 = 32'd5;
      #1;
      check("mul_result2", Result2, mul_exp);
      check("mul_flags2", {28'd0, Flags2}, {28'd0, mul_f});

      // Randomized run against the reference model, including occasional resets.
      mflags = FlagsReg;
      check("rand_start_flags", {28'd0, FlagsReg}, 32'h9);
      mflags = 4'h9;
      for (int it = 0; it < 400; it++) begin
         @(negedge Clock);
         Op          = 4'($urandom_range(0, 15));
         Source1     = pick();
         Source2     = ($urandom_range(0, 3) == 0) ? Source1 : pick();
         Cond        = 4'($urandom_range(0, 15));
         CompSource1 = pick();
         CompSource2 = ($urandom_range(0, 3) == 0) ? CompSource1 : pick();
         FlagEnable  = 1'($urandom_range(0, 1));
         FlagSel     = 1'($urandom_range(0, 1));
         Reset       = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
         #1;
         m2 = m_alu2(Op, Source1, Source2);
         m1 = m_alu1(Op, Source1);
         check($sformatf("rand%0d_result2 op=%h a=%h b=%h", it, Op, Source1, Source2), Result2, m2[31:0]);
         check($sformatf("rand%0d_flags2 op=%h a=%h b=%h", it, Op, Source1, Source2),
               {28'd0, Flags2}, {28'd0, m2[35:32]});
         check($sformatf("rand%0d_result1 op=%h a=%h", it, Op, Source1), Result1, m1[31:0]);
         check($sformatf("rand%0d_flags1 op=%h a=%h", it, Op, Source1),
               {28'd0, Flags1}, {28'd0, m1[35:32]});
         check($sformatf("rand%0d_cond c=%h", it, Cond), {31'd0, CondTrue},
               {31'd0, m_cond(Cond, CompSource1, CompSource2, mflags)});
         if (!Reset)          mflags = 4'h0;
         else if (FlagEnable) mflags = FlagSel ? m2[35:32] : m1[35:32];
         @(posedge Clock); #1;
         check($sformatf("rand%0d_flagsreg", it), {28'd0, FlagsReg}, {28'd0, mflags});
      end
      Reset = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
